// File: rtl/hex_disp_sched.sv
// Seven-segment display scheduler: three strobed 7-bit sources share one
// round-robin arbitrated double-dabble converter feeding per-digit registers.
module hex_disp_sched (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic [6:0] seq_num,
    input  logic       seq_upd,
    input  logic [6:0] freq_num,
    input  logic       freq_upd,
    input  logic [6:0] rom_addr,
    input  logic       rom_upd,
    output logic       busy,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic [0:6] HEX3,
    output logic [0:6] HEX4,
    output logic [0:6] HEX5,
    output logic [0:6] HEX6
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WRITE} state_t;

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_FREQ = 2'd1;
    localparam logic [1:0] SRC_ROM  = 2'd2;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    state_t      r_state;
    state_t      w_next_state;

    logic [6:0]  r_sh_seq;
    logic [6:0]  r_sh_freq;
    logic [6:0]  r_sh_rom;
    logic [2:0]  r_pend;
    logic [1:0]  r_last_grant;
    logic [1:0]  r_grant;
    logic [6:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;

    logic [3:0]  r_seq_hund;
    logic [3:0]  r_seq_tens;
    logic [3:0]  r_seq_ones;
    logic [3:0]  r_freq_ones;
    logic [3:0]  r_rom_hund;
    logic [3:0]  r_rom_tens;
    logic [3:0]  r_rom_ones;

    logic [2:0]  w_upd;
    logic        w_any;
    logic [1:0]  w_winner;
    logic [6:0]  w_win_val;
    logic [2:0]  w_clr;
    logic        w_grant_en;
    logic        w_shift_en;
    logic        w_write_en;
    logic [11:0] w_bcd_adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign w_upd = {rom_upd, freq_upd, seq_upd};

    // Round-robin: search starts one past the last granted source.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_winner  = SRC_SEQ;
        w_win_val = r_sh_seq;
        w_any     = |r_pend;
        case (r_last_grant)
            SRC_SEQ:  w_winner = r_pend[1] ? SRC_FREQ : (r_pend[2] ? SRC_ROM : SRC_SEQ);
            SRC_FREQ: w_winner = r_pend[2] ? SRC_ROM : (r_pend[0] ? SRC_SEQ : SRC_FREQ);
            default:  w_winner = r_pend[0] ? SRC_SEQ : (r_pend[1] ? SRC_FREQ : SRC_ROM);
        endcase
        case (w_winner)
            SRC_FREQ: w_win_val = r_sh_freq;
            SRC_ROM:  w_win_val = r_sh_rom;
            default:  w_win_val = r_sh_seq;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_SHIFT;
            S_SHIFT: if (r_cnt == 3'd6) w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant_en = (r_state == S_IDLE) && w_any;
        w_shift_en = (r_state == S_SHIFT);
        w_write_en = (r_state == S_WRITE);
        busy       = (r_state != S_IDLE);
        w_clr      = w_grant_en ? (3'b001 << w_winner) : 3'b000;
    end

    assign w_bcd_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

    // A new strobe beats the grant's clear, so a same-cycle update is never lost.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_sh_seq  <= '0;
            r_sh_freq <= '0;
            r_sh_rom  <= '0;
            r_pend    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (seq_upd)  r_sh_seq  <= seq_num;
            if (freq_upd) r_sh_freq <= freq_num;
            if (rom_upd)  r_sh_rom  <= rom_addr;
            r_pend <= w_upd | (r_pend & ~w_clr);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_last_grant <= SRC_ROM;
            r_grant      <= SRC_SEQ;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
        end else if (w_grant_en) begin
            r_last_grant <= w_winner;
            r_grant      <= w_winner;
            r_bin        <= w_win_val;
            r_bcd        <= '0;
            r_cnt        <= '0;
        end else if (w_shift_en) begin
            {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + 3'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_seq_hund  <= '0;
            r_seq_tens  <= '0;
            r_seq_ones  <= '0;
            r_freq_ones <= '0;
            r_rom_hund  <= '0;
            r_rom_tens  <= '0;
            r_rom_ones  <= '0;
        end else if (w_write_en) begin
            case (r_grant)
                SRC_SEQ: begin
                    r_seq_hund <= r_bcd[11:8];
                    r_seq_tens <= r_bcd[7:4];
                    r_seq_ones <= r_bcd[3:0];
                end
                SRC_FREQ: r_freq_ones <= r_bcd[3:0];
                default: begin
                    r_rom_hund <= r_bcd[11:8];
                    r_rom_tens <= r_bcd[7:4];
                    r_rom_ones <= r_bcd[3:0];
                end
            endcase
        end
    end

    // Leading zeros are blanked; the seq hundreds digit only gates HEX1 blanking.
    always_comb begin
        HEX0 = seg7(r_seq_ones);
        HEX1 = (r_seq_tens == 4'd0 && r_seq_hund == 4'd0) ? SEG_BLANK : seg7(r_seq_tens);
        HEX2 = seg7(r_freq_ones);
        HEX3 = seg7(r_rom_ones);
        HEX4 = (r_rom_tens == 4'd0 && r_rom_hund == 4'd0) ? SEG_BLANK : seg7(r_rom_tens);
        HEX5 = (r_rom_hund == 4'd0) ? SEG_BLANK : seg7(r_rom_hund);
        HEX6 = SEG_BLANK;
    end

endmodule

// File: doc/hex_disp_sched.md
# hex_disp_sched

Display scheduler for the DE2 seven-segment bank. It captures three 7-bit status values (sequence number, frequency number, ROM address), each with its own update strobe. A round-robin arbiter shares one iterative binary-to-BCD (double-dabble) converter among the three sources, and the results are written into per-digit registers. The registers are decoded to active-low segment patterns on HEX0–HEX6. The block sits between the top-level control datapath and the board displays.

## Interface

Parameters: none.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge
- KEY0  in  1  reset, asynchronous, active-low
- seq_num  in  7  sequence number value
- seq_upd  in  1  1-cycle strobe: capture seq_num, request display refresh
- freq_num  in  7  frequency number value
- freq_upd  in  1  strobe for freq_num
- rom_addr  in  7  ROM address value
- rom_upd  in  1  strobe for rom_addr
- busy  out  1  high while the converter is not IDLE
- HEX0..HEX6  out  [0:6] each  active-low segments, index 0 = a … 6 = g

## Operation

**Capture**
- On an edge with x_upd=1, shadow_x ← x value and pend_x ← 1.
- A strobe on a source that is already pending overwrites its shadow (latest wins) and produces one conversion only.

**Arbitration**
- Round-robin over seq(0), freq(1), rom(2).
- Search starts at last_grant+1 mod 3.
- last_grant resets to 2, so seq wins first after reset.

**FSM: IDLE, SHIFT, WRITE**
- IDLE with any pend set: grant the winner, load bin ← shadow, clear bcd, cnt ← 0, clear pend of the winner, last_grant ← winner, go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble ≥5 (hundreds, tens, ones), then shift {bcd,bin} left by 1; cnt++. After 7 shift cycles go to WRITE.
- WRITE: copy the BCD digits into the granted source's digit registers, then go to IDLE.

**Digit mapping**
- seq: HEX1 = tens, HEX0 = ones. The hundreds digit is dropped.
- freq: HEX2 = ones only.
- rom: HEX5 = hundreds, HEX4 = tens, HEX3 = ones.
- HEX6: constant blank (7'b1111111).

**Blanking**
- The ones digit is always shown.
- rom: HEX5 is blank if hundreds=0; HEX4 is blank if hundreds=0 and tens=0.
- seq: HEX1 is blank if tens=0 and hundreds=0.

**Segment decode**
- Combinational from registered digits, active-low.
- Examples (a..g order): 0 = 0000001, 1 = 1001111, 2 = 0010010, 7 = 0001111, 9 = 0000100.

**Width rule**
- Inputs are 0–127, so hundreds ≤1 and no overflow is possible. Nibbles are 4 bits.

**Simultaneous events**
- x_upd in the same cycle that pend_x is cleared by a grant: the set wins. Pend stays 1 and the shadow takes the new value.
- x_upd while x is being converted: the conversion continues on the loaded value, and x is reconverted later under round-robin order.

## Timing

**Reset (KEY0=0, async)**
- FSM IDLE, all pend 0, shadows 0, digit regs 0, last_grant 2, busy 0.
- HEX0 = 0, HEX1 blank, HEX2 = 0, HEX3 = 0, HEX4 blank, HEX5 blank, HEX6 blank.
- Reset mid-conversion aborts it; pending requests are lost.

**Latency**
- Strobe sampled at edge N (pend set).
- Grant/load at N+1.
- Shifts at N+2..N+8.
- WRITE at N+9; HEX valid after edge N+9, i.e. 9 cycles.

**Throughput**
- One conversion per 9 cycles. The next grant can occur on the edge after WRITE (N+10).

**busy**
- High from the edge after the grant through the WRITE cycle.
- Low in IDLE.
- Registered, i.e. derived from the state register.

**Outputs**
- A source's HEX lines change only on that source's WRITE edge.
- Other sources' displays never glitch.

## Test plan

- **Reset:** KEY0 low, then released, no strobes → HEX0 = 0000001, HEX2 = 0000001, HEX3 = 0000001; HEX1, HEX4, HEX5, HEX6 = 1111111; busy = 0.
- **Single update:** seq_num=42, seq_upd 1 cycle → busy rises the cycle after the grant; 9 cycles after the strobe HEX1 = 1001100 (4), HEX0 = 0010010 (2); other HEX unchanged.
- **Simultaneous strobes:** seq=5, freq=9, rom=127 strobed in the same cycle → WRITEs occur in order seq, freq, rom at +9, +18, +27. Final state: HEX0 = 5, HEX1 blank, HEX2 = 9, HEX5/HEX4/HEX3 = 1/2/7.
- **Blanking and hundreds drop:** rom_addr=7 → HEX5 and HEX4 blank, HEX3 = 7. seq_num=100 → HEX1 = 0, HEX0 = 0.
- **Re-strobe mid-conversion:** seq_num=10 strobed, then seq_num=99 strobed during SHIFT → display shows 10 at the first WRITE, then 99 after a second conversion. Two strobes on a pending source before its grant → exactly one conversion showing the latest value.
- **Reset mid-conversion:** assert KEY0 during SHIFT for rom_addr=127 → outputs return to reset values at once, busy = 0, and no WRITE follows after release.
